gbe_rx_frame_counter: RTL and testbench
=======================================

Name: gbe_rx_frame_counter

Overview:
Monitors the 10GbE core RX interface in the user_clk domain and produces registered frame statistics.
good_ctr drives the user_data_in port of the gbe1 rxctr software register. bad_ctr, overrun_ctr and last_len feed sibling software registers.
The block is passive: it only observes the RX bus and never back-pressures it.

Parameters:
CTR_W, 32, width of good_ctr, bad_ctr and overrun_ctr
LEN_W, 16, width of last_len; the internal word counter saturates at 2^LEN_W-1
SATURATE, 0, 0 = counters wrap (all-ones -> 0); 1 = counters hold at all-ones

Ports:
user_clk  in  1  RX user clock; all logic on rising edge
user_rst  in  1  asynchronous, active-high reset
rx_valid  in  1  RX data word valid this cycle
rx_end_of_frame  in  1  last word of frame; qualified by rx_valid
rx_bad_frame  in  1  CRC/framing error; sampled only on the EOF word
rx_overrun  in  1  core RX buffer overrun flag, level
ctr_en  in  1  counting enable, level, from a software register
ctr_rst  in  1  counter clear request, level, from a software register; the rising edge acts
good_ctr  out  CTR_W  count of good frames
bad_ctr  out  CTR_W  count of frames with rx_bad_frame=1 on EOF
overrun_ctr  out  CTR_W  count of rx_overrun rising edges
last_len  out  LEN_W  word length of the most recent completed frame (good or bad)
in_frame  out  1  FSM is in IN_FRAME

Behaviour:
- Reset (async, user_rst=1): all outputs = 0, FSM = IDLE, ctr_rst and rx_overrun edge registers = 0, word counter = 0.
- FSM states: IDLE, IN_FRAME.
  - IDLE, rx_valid & !rx_end_of_frame -> IN_FRAME; word counter = 1.
  - IDLE, rx_valid & rx_end_of_frame -> single-word frame; completes with length 1; stays IDLE.
  - IN_FRAME, rx_valid & !rx_end_of_frame -> word counter +1, saturating at 2^LEN_W-1.
  - IN_FRAME, rx_valid & rx_end_of_frame -> frame completes with length = counter+1 (saturating); -> IDLE.
  - rx_valid=0 in any state -> no change; gaps inside a frame are legal.
- Frame completion (EOF cycle):
  - last_len is loaded regardless of ctr_en.
  - If ctr_en=1: rx_bad_frame=1 -> bad_ctr+1, else good_ctr+1.
  - If ctr_en=0: neither counter changes.
- Latency: the counter and last_len update is visible on the clock edge that samples the EOF word, i.e. 1 cycle after EOF is presented.
- overrun_ctr: +1 on each 0->1 transition of rx_overrun while ctr_en=1. A held-high level counts once.
- Clear: a rising edge of ctr_rst (registered edge detect) zeroes good_ctr, bad_ctr, overrun_ctr and last_len next cycle.
  - The FSM is not affected; a frame in progress is still counted when its EOF arrives.
  - Clear and a count event in the same cycle: clear applies first, then the event, so the affected counter = 1.
- Width rules: SATURATE=0 wraps all-ones -> 0. SATURATE=1 holds all-ones.
- Mid-frame async reset: the remaining words of the interrupted frame are treated as a new frame. Its length counts only the words after reset.
- in_frame is registered and mirrors state == IN_FRAME.

Optional Feature:
RXCTR_ERR_CNT_EN
- Defined: bad_ctr and overrun_ctr logic is instantiated as described above.
- Undefined: bad_ctr and overrun_ctr are tied to 0, and their edge-detect and counter logic is removed.
  - Bad frames are then neither good nor counted, but still load last_len.
  - good_ctr and last_len behaviour is unchanged.

Test Plan:
1. Reset, ctr_en=1; send 3 good frames of 4 words each (EOF on word 4, rx_bad_frame=0) -> good_ctr=3, bad_ctr=0, last_len=4, in_frame=0 after each EOF.
2. Send a 2-word frame with rx_bad_frame=1 on EOF, then a 1-word frame (valid+EOF same cycle) -> bad_ctr=1, good_ctr=1, last_len=1; FSM never enters IN_FRAME for the 1-word frame.
3. SATURATE=0, CTR_W=4: 17 good frames -> good_ctr=1 (wrapped). SATURATE=1: same stimulus -> good_ctr=15.
4. Toggle ctr_rst 0->1 on the same cycle as a good frame's EOF, with good_ctr=5 beforehand -> good_ctr=1 next cycle; holding ctr_rst high for 10 more cycles causes no further clears.
5. Hold rx_overrun high for 20 cycles, low for 1 cycle, high again -> overrun_ctr=2. With the macro undefined -> overrun_ctr=0.
6. ctr_en=0 during a 3-word frame, then assert user_rst after word 2 of a 5-word frame and send the remaining 3 words -> counters unchanged by the first frame; after reset, good_ctr=0 (ctr_en=0 as well), last_len=3.

Source files
------------

// File: rtl/gbe_rx_frame_counter_if.sv
// -----------------------------------------------------------------------------
// gbe_rx_frame_counter_if
//
// Purpose:
//   Groups the 10GbE core RX status signals observed by gbe_rx_frame_counter.
//   The core (or a testbench standing in for it) drives the signals through
//   the master modport. The counter only observes them through the slave
//   modport.
//
// Signals:
//   rx_valid         RX data word valid this cycle
//   rx_end_of_frame  last word of frame, qualified by rx_valid
//   rx_bad_frame     CRC/framing error, meaningful only on the EOF word
//   rx_overrun       core RX buffer overrun flag (level)
//
// Handshake: the bus has no ready signal. A word is transferred on every rising
//   user_clk edge where rx_valid=1. The observer never back-pressures the bus.
// -----------------------------------------------------------------------------
interface gbe_rx_frame_counter_if;
    logic rx_valid;
    logic rx_end_of_frame;
    logic rx_bad_frame;
    logic rx_overrun;

    modport master (
        output rx_valid,
        output rx_end_of_frame,
        output rx_bad_frame,
        output rx_overrun
    );

    modport slave (
        input rx_valid,
        input rx_end_of_frame,
        input rx_bad_frame,
        input rx_overrun
    );
endinterface

// File: rtl/gbe_rx_frame_counter.sv
// -----------------------------------------------------------------------------
// gbe_rx_frame_counter
//
// Purpose:
//   Passive monitor of the 10GbE RX bus in the user_clk domain. It counts good
//   frames, bad frames and overrun events, and it records the word length of
//   the last completed frame. good_ctr feeds the gbe1 rxctr software register.
//   The other outputs feed sibling registers.
//
// Optional feature (macro RXCTR_ERR_CNT_EN):
//   Defined   : bad_ctr and overrun_ctr are counted.
//   Undefined : bad_ctr and overrun_ctr are tied to 0, and their logic is
//               removed. Bad frames are not counted as good frames, but they
//               still load last_len.
//
// Parameters:
//   CTR_W    width of good_ctr / bad_ctr / overrun_ctr
//   LEN_W    width of last_len. The word counter saturates at 2^LEN_W-1.
//   SATURATE 0 = counters wrap, 1 = counters hold at all-ones
//
// Ports:
//   user_clk     RX user clock. All logic runs on its rising edge.
//   user_rst     asynchronous, active-high reset
//   rx           RX bus (slave modport of gbe_rx_frame_counter_if)
//   ctr_en       counting enable (level)
//   ctr_rst      counter clear request. Its rising edge clears the counters.
//   good_ctr     good frame count
//   bad_ctr      bad frame count
//   overrun_ctr  count of rx_overrun rising edges
//   last_len     word length of the most recent completed frame
//   in_frame     registered copy of (state == IN_FRAME)
// -----------------------------------------------------------------------------
module gbe_rx_frame_counter #(
    parameter int CTR_W    = 32,
    parameter int LEN_W    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic                       user_clk,
    input  logic                       user_rst,
    gbe_rx_frame_counter_if.slave      rx,
    input  logic                       ctr_en,
    input  logic                       ctr_rst,
    output logic [CTR_W-1:0]           good_ctr,
    output logic [CTR_W-1:0]           bad_ctr,
    output logic [CTR_W-1:0]           overrun_ctr,
    output logic [LEN_W-1:0]           last_len,
    output logic                       in_frame
);

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] word_cnt;
    logic             ctr_rst_q;
    logic             clr;
    logic             eof_word;
    logic [LEN_W-1:0] frame_len;
    logic [CTR_W-1:0] good_nxt;
    logic [LEN_W-1:0] len_nxt;

    // Statistics counter increment. The counter wraps or holds at all-ones,
    // depending on SATURATE.
    function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] v);
        if (SATURATE && (&v))
            return v;
        else
            return v + CTR_W'(1);
    endfunction

    // The word counter always saturates, so very long frames report the max.
    function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] v);
        if (&v)
            return v;
        else
            return v + LEN_W'(1);
    endfunction

    assign clr       = ctr_rst & ~ctr_rst_q;
    assign eof_word  = rx.rx_valid & rx.rx_end_of_frame;
    // A frame that completes from IDLE is a single-word frame.
    assign frame_len = (state == IDLE) ? LEN_W'(1) : len_inc(word_cnt);

    // Frame-tracking FSM. in_frame is registered together with the state.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            in_frame <= 1'b0;
        end else if (rx.rx_valid) begin
            case (state)
                IDLE: begin
                    if (!rx.rx_end_of_frame) begin
                        state    <= IN_FRAME;
                        word_cnt <= LEN_W'(1);
                        in_frame <= 1'b1;
                    end
                end
                IN_FRAME: begin
                    if (rx.rx_end_of_frame) begin
                        state    <= IDLE;
                        word_cnt <= '0;
                        in_frame <= 1'b0;
                    end else begin
                        word_cnt <= len_inc(word_cnt);
                    end
                end
                default: begin
                    state    <= IDLE;
                    word_cnt <= '0;
                    in_frame <= 1'b0;
                end
            endcase
        end
    end

    // The clear is edge-detected against the previous ctr_rst sample, so
    // holding ctr_rst high clears only once.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst)
            ctr_rst_q <= 1'b0;
        else
            ctr_rst_q <= ctr_rst;
    end

    // The clear is applied first and the event second. A count event in the
    // same cycle as a clear therefore leaves the counter at 1.
    always_comb begin
        good_nxt = clr ? '0 : good_ctr;
        len_nxt  = clr ? '0 : last_len;
        if (eof_word) begin
            len_nxt = frame_len;
            if (ctr_en && !rx.rx_bad_frame)
                good_nxt = ctr_inc(good_nxt);
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            good_ctr <= '0;
            last_len <= '0;
        end else begin
            good_ctr <= good_nxt;
            last_len <= len_nxt;
        end
    end

`ifdef RXCTR_ERR_CNT_EN
    logic             overrun_q;
    logic             overrun_rise;
    logic [CTR_W-1:0] bad_nxt;
    logic [CTR_W-1:0] overrun_nxt;

    assign overrun_rise = rx.rx_overrun & ~overrun_q;

    always_comb begin
        bad_nxt     = clr ? '0 : bad_ctr;
        overrun_nxt = clr ? '0 : overrun_ctr;
        if (eof_word && ctr_en && rx.rx_bad_frame)
            bad_nxt = ctr_inc(bad_nxt);
        if (overrun_rise && ctr_en)
            overrun_nxt = ctr_inc(overrun_nxt);
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            overrun_q   <= 1'b0;
            bad_ctr     <= '0;
            overrun_ctr <= '0;
        end else begin
            overrun_q   <= rx.rx_overrun;
            bad_ctr     <= bad_nxt;
            overrun_ctr <= overrun_nxt;
        end
    end
`else
    // The error counters are compiled out. The overrun flag has no consumer.
    logic unused_overrun;
    assign unused_overrun = rx.rx_overrun;
    assign bad_ctr        = '0;
    assign overrun_ctr    = '0;
`endif

endmodule

// File: tb/tb_gbe_rx_frame_counter.sv
// -----------------------------------------------------------------------------
// tb_gbe_rx_frame_counter
//
// Directed testbench for gbe_rx_frame_counter.
//
// DUT instances:
//   dut     CTR_W=32, LEN_W=16, SATURATE=0
//   dut_w4  CTR_W=4,  SATURATE=0 (wrap)
//   dut_s4  CTR_W=4,  LEN_W=2, SATURATE=1 (hold)
//
// All three instances observe the same RX interface and control inputs.
//
// Timing: inputs are driven on the falling clock edge. Outputs are sampled on a
//   later falling edge, after the rising edge that acts on the inputs.
// -----------------------------------------------------------------------------
module tb_gbe_rx_frame_counter;

`ifdef RXCTR_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ctr_en;
    logic        ctr_rst;
    logic [31:0] good_ctr, bad_ctr, overrun_ctr;
    logic [15:0] last_len;
    logic        in_frame;
    logic [3:0]  w4_good, w4_bad, w4_ovr;
    logic [15:0] w4_len;
    logic        w4_in;
    logic [3:0]  s4_good, s4_bad, s4_ovr;
    logic [1:0]  s4_len;
    logic        s4_in;

    int check_cnt = 0;
    int pass_cnt  = 0;

    gbe_rx_frame_counter_if rx_if ();

    gbe_rx_frame_counter #(.CTR_W(32), .LEN_W(16), .SATURATE(1'b0)) dut (
        .user_clk(clk), .user_rst(rst), .rx(rx_if),
        .ctr_en(ctr_en), .ctr_rst(ctr_rst),
        .good_ctr(good_ctr), .bad_ctr(bad_ctr), .overrun_ctr(overrun_ctr),
        .last_len(last_len), .in_frame(in_frame)
    );

    gbe_rx_frame_counter #(.CTR_W(4), .LEN_W(16), .SATURATE(1'b0)) dut_w4 (
        .user_clk(clk), .user_rst(rst), .rx(rx_if),
        .ctr_en(ctr_en), .ctr_rst(ctr_rst),
        .good_ctr(w4_good), .bad_ctr(w4_bad), .overrun_ctr(w4_ovr),
        .last_len(w4_len), .in_frame(w4_in)
    );

    gbe_rx_frame_counter #(.CTR_W(4), .LEN_W(2), .SATURATE(1'b1)) dut_s4 (
        .user_clk(clk), .user_rst(rst), .rx(rx_if),
        .ctr_en(ctr_en), .ctr_rst(ctr_rst),
        .good_ctr(s4_good), .bad_ctr(s4_bad), .overrun_ctr(s4_ovr),
        .last_len(s4_len), .in_frame(s4_in)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst                   = 1'b1;
        ctr_rst               = 1'b0;
        rx_if.rx_valid        = 1'b0;
        rx_if.rx_end_of_frame = 1'b0;
        rx_if.rx_bad_frame    = 1'b0;
        rx_if.rx_overrun      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- drivers ----------------
    // Sends a frame of len words, one word per cycle. The task then idles for
    // one cycle, and the caller checks the outputs at that point. saw_in
    // records whether in_frame was ever high before the EOF word was accepted.
    // With clr_on_eof set, ctr_rst rises together with the EOF word and is left
    // high when the task returns.
    task automatic send_frame(input int len, input bit bad, input bit clr_on_eof,
                              output bit saw_in);
        saw_in = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i > 0) saw_in = saw_in | in_frame;
            rx_if.rx_valid        = 1'b1;
            rx_if.rx_end_of_frame = (i == len - 1);
            rx_if.rx_bad_frame    = bad && (i == len - 1);
            if (clr_on_eof && (i == len - 1)) ctr_rst = 1'b1;
        end
        @(negedge clk);
        rx_if.rx_valid        = 1'b0;
        rx_if.rx_end_of_frame = 1'b0;
        rx_if.rx_bad_frame    = 1'b0;
    endtask

    task automatic send_word(input bit eof);
        @(negedge clk);
        rx_if.rx_valid        = 1'b1;
        rx_if.rx_end_of_frame = eof;
        rx_if.rx_bad_frame    = 1'b0;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        rx_if.rx_valid        = 1'b0;
        rx_if.rx_end_of_frame = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ctr_en = 1'b1;
        apply_reset();
        check_cnt++; if (good_ctr !== 32'd0) $display("FAIL reset_good: got %0d expected 0", good_ctr); else pass_cnt++;
        check_cnt++; if (bad_ctr !== 32'd0) $display("FAIL reset_bad: got %0d expected 0", bad_ctr); else pass_cnt++;
        check_cnt++; if (overrun_ctr !== 32'd0) $display("FAIL reset_overrun: got %0d expected 0", overrun_ctr); else pass_cnt++;
        check_cnt++; if (last_len !== 16'd0) $display("FAIL reset_len: got %0d expected 0", last_len); else pass_cnt++;
        check_cnt++; if (in_frame !== 1'b0) $display("FAIL reset_in_frame: got %0b expected 0", in_frame); else pass_cnt++;
    endtask

    task automatic test_good_frames();
        bit saw;
        apply_reset();
        for (int f = 1; f <= 3; f++) begin
            send_frame(4, 1'b0, 1'b0, saw);
            check_cnt++; if (good_ctr !== 32'(f)) $display("FAIL good_frames_good: got %0d expected %0d", good_ctr, f); else pass_cnt++;
            check_cnt++; if (bad_ctr !== 32'd0) $display("FAIL good_frames_bad: got %0d expected 0", bad_ctr); else pass_cnt++;
            check_cnt++; if (last_len !== 16'd4) $display("FAIL good_frames_len: got %0d expected 4", last_len); else pass_cnt++;
            check_cnt++; if (in_frame !== 1'b0) $display("FAIL good_frames_in_frame_after: got %0b expected 0", in_frame); else pass_cnt++;
            check_cnt++; if (saw !== 1'b1) $display("FAIL good_frames_in_frame_mid: got %0b expected 1", saw); else pass_cnt++;
        end
    endtask

    task automatic test_bad_and_single();
        bit saw;
        apply_reset();
        send_frame(2, 1'b1, 1'b0, saw);
        check_cnt++; if (bad_ctr !== (ERR_EN ? 32'd1 : 32'd0)) $display("FAIL bad_frame_bad: got %0d expected %0d", bad_ctr, ERR_EN ? 1 : 0); else pass_cnt++;
        check_cnt++; if (good_ctr !== 32'd0) $display("FAIL bad_frame_good: got %0d expected 0", good_ctr); else pass_cnt++;
        check_cnt++; if (last_len !== 16'd2) $display("FAIL bad_frame_len: got %0d expected 2", last_len); else pass_cnt++;
        send_frame(1, 1'b0, 1'b0, saw);
        check_cnt++; if (good_ctr !== 32'd1) $display("FAIL single_good: got %0d expected 1", good_ctr); else pass_cnt++;
        check_cnt++; if (bad_ctr !== (ERR_EN ? 32'd1 : 32'd0)) $display("FAIL single_bad: got %0d expected %0d", bad_ctr, ERR_EN ? 1 : 0); else pass_cnt++;
        check_cnt++; if (last_len !== 16'd1) $display("FAIL single_len: got %0d expected 1", last_len); else pass_cnt++;
        check_cnt++; if (saw !== 1'b0) $display("FAIL single_in_frame: got %0b expected 0", saw); else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit saw;
        apply_reset();
        for (int f = 1; f <= 17; f++) begin
            send_frame(2, 1'b0, 1'b0, saw);
            if (f == 15) begin
                check_cnt++; if (w4_good !== 4'd15) $display("FAIL wrap_w4_at15: got %0d expected 15", w4_good); else pass_cnt++;
            end
            if (f == 16) begin
                check_cnt++; if (w4_good !== 4'd0) $display("FAIL wrap_w4_at16: got %0d expected 0", w4_good); else pass_cnt++;
                check_cnt++; if (s4_good !== 4'd15) $display("FAIL sat_s4_at16: got %0d expected 15", s4_good); else pass_cnt++;
            end
        end
        check_cnt++; if (good_ctr !== 32'd17) $display("FAIL wrap_main_17: got %0d expected 17", good_ctr); else pass_cnt++;
        check_cnt++; if (w4_good !== 4'd1) $display("FAIL wrap_w4_17: got %0d expected 1", w4_good); else pass_cnt++;
        check_cnt++; if (s4_good !== 4'd15) $display("FAIL sat_s4_17: got %0d expected 15", s4_good); else pass_cnt++;
        // A 5-word frame overflows the 2-bit length field of dut_s4.
        send_frame(5, 1'b0, 1'b0, saw);
        check_cnt++; if (last_len !== 16'd5) $display("FAIL len_main_5: got %0d expected 5", last_len); else pass_cnt++;
        check_cnt++; if (s4_len !== 2'd3) $display("FAIL len_sat_s4: got %0d expected 3", s4_len); else pass_cnt++;
    endtask

    task automatic test_clear();
        bit saw;
        apply_reset();
        for (int f = 0; f < 5; f++) send_frame(2, 1'b0, 1'b0, saw);
        check_cnt++; if (good_ctr !== 32'd5) $display("FAIL clear_pre_good: got %0d expected 5", good_ctr); else pass_cnt++;
        // The clear and the EOF are seen on the same edge.
        send_frame(2, 1'b0, 1'b1, saw);
        check_cnt++; if (good_ctr !== 32'd1) $display("FAIL clear_eof_good: got %0d expected 1", good_ctr); else pass_cnt++;
        check_cnt++; if (last_len !== 16'd2) $display("FAIL clear_eof_len: got %0d expected 2", last_len); else pass_cnt++;
        // ctr_rst held high: a further frame still counts normally.
        repeat (4) @(negedge clk);
        send_frame(3, 1'b0, 1'b0, saw);
        repeat (2) @(negedge clk);
        check_cnt++; if (good_ctr !== 32'd2) $display("FAIL clear_held_good: got %0d expected 2", good_ctr); else pass_cnt++;
        check_cnt++; if (last_len !== 16'd3) $display("FAIL clear_held_len: got %0d expected 3", last_len); else pass_cnt++;
        ctr_rst = 1'b0;
        @(negedge clk);
        ctr_rst = 1'b1;
        @(negedge clk);
        check_cnt++; if (good_ctr !== 32'd0) $display("FAIL clear_plain_good: got %0d expected 0", good_ctr); else pass_cnt++;
        check_cnt++; if (last_len !== 16'd0) $display("FAIL clear_plain_len: got %0d expected 0", last_len); else pass_cnt++;
        ctr_rst = 1'b0;
    endtask

    task automatic test_overrun();
        apply_reset();
        @(negedge clk);
        rx_if.rx_overrun = 1'b1;
        repeat (10) @(negedge clk);
        check_cnt++; if (overrun_ctr !== (ERR_EN ? 32'd1 : 32'd0)) $display("FAIL overrun_held: got %0d expected %0d", overrun_ctr, ERR_EN ? 1 : 0); else pass_cnt++;
        repeat (10) @(negedge clk);
        rx_if.rx_overrun = 1'b0;
        @(negedge clk);
        rx_if.rx_overrun = 1'b1;
        repeat (3) @(negedge clk);
        rx_if.rx_overrun = 1'b0;
        @(negedge clk);
        check_cnt++; if (overrun_ctr !== (ERR_EN ? 32'd2 : 32'd0)) $display("FAIL overrun_two: got %0d expected %0d", overrun_ctr, ERR_EN ? 2 : 0); else pass_cnt++;
        // A rising edge while counting is disabled is ignored.
        ctr_en = 1'b0;
        rx_if.rx_overrun = 1'b1;
        @(negedge clk);
        rx_if.rx_overrun = 1'b0;
        @(negedge clk);
        check_cnt++; if (overrun_ctr !== (ERR_EN ? 32'd2 : 32'd0)) $display("FAIL overrun_disabled: got %0d expected %0d", overrun_ctr, ERR_EN ? 2 : 0); else pass_cnt++;
        ctr_en = 1'b1;
    endtask

    task automatic test_disable_and_reset();
        bit saw;
        ctr_en = 1'b1;
        apply_reset();
        send_frame(2, 1'b0, 1'b0, saw);
        ctr_en = 1'b0;
        send_frame(3, 1'b0, 1'b0, saw);
        check_cnt++; if (good_ctr !== 32'd1) $display("FAIL disabled_good: got %0d expected 1", good_ctr); else pass_cnt++;
        check_cnt++; if (last_len !== 16'd3) $display("FAIL disabled_len: got %0d expected 3", last_len); else pass_cnt++;
        send_frame(2, 1'b1, 1'b0, saw);
        check_cnt++; if (bad_ctr !== 32'd0) $display("FAIL disabled_bad: got %0d expected 0", bad_ctr); else pass_cnt++;
        check_cnt++; if (last_len !== 16'd2) $display("FAIL disabled_bad_len: got %0d expected 2", last_len); else pass_cnt++;
        // The 5-word frame is interrupted by a reset after its second word.
        send_word(1'b0);
        send_word(1'b0);
        idle_bus();
        rst = 1'b1;
        #1;
        check_cnt++; if (good_ctr !== 32'd0) $display("FAIL async_rst_good: got %0d expected 0", good_ctr); else pass_cnt++;
        check_cnt++; if (in_frame !== 1'b0) $display("FAIL async_rst_in_frame: got %0b expected 0", in_frame); else pass_cnt++;
        check_cnt++; if (last_len !== 16'd0) $display("FAIL async_rst_len: got %0d expected 0", last_len); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        send_word(1'b0);
        send_word(1'b0);
        send_word(1'b1);
        idle_bus();
        check_cnt++; if (good_ctr !== 32'd0) $display("FAIL post_rst_good: got %0d expected 0", good_ctr); else pass_cnt++;
        check_cnt++; if (last_len !== 16'd3) $display("FAIL post_rst_len: got %0d expected 3", last_len); else pass_cnt++;
        check_cnt++; if (in_frame !== 1'b0) $display("FAIL post_rst_in_frame: got %0b expected 0", in_frame); else pass_cnt++;
        ctr_en = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst                   = 1'b1;
        ctr_en                = 1'b0;
        ctr_rst               = 1'b0;
        rx_if.rx_valid        = 1'b0;
        rx_if.rx_end_of_frame = 1'b0;
        rx_if.rx_bad_frame    = 1'b0;
        rx_if.rx_overrun      = 1'b0;

        test_reset();
        test_good_frames();
        test_bad_and_single();
        test_wrap();
        test_clear();
        test_overrun();
        test_disable_and_reset();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
